mode_select_ctrl: RTL
=====================

# mode_select_ctrl

Input-side companion to the display output selector. It owns the mode `select` code that the selector consumes, and advances that code on a debounced mode button. It routes a shared 4-bit entry value into one of three per-mode holding registers (timer, clock, stopwatch) through a valid/ready handshake. It sits between the board buttons/switches and the timer, clock and stopwatch datapaths.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4: number of consecutive high synchronised samples needed to accept a press (legal range 1–255).

Ports:
- `clk`  in  1: system clock. Single clock domain.
- `n_rst`  in  1: reset. Synchronous, active-low.
- `mode_btn`  in  1: raw mode button. Asynchronous; synchronised internally.
- `data_in`  in  4: entry value.
- `data_valid`  in  1: `data_in` is offered this cycle.
- `data_ready`  out  1: block accepts `data_in` this cycle.
- `select`  out  2: mode code. 00 = off, 01 = timer, 10 = clock, 11 = stopwatch.
- `timer_val`  out  4: timer holding register.
- `clock_val`  out  4: clock holding register.
- `stopwatch_val`  out  4: stopwatch holding register.
- `load_timer`  out  1: one-cycle pulse; `timer_val` updated.
- `load_clock`  out  1: one-cycle pulse; `clock_val` updated.
- `load_stopwatch`  out  1: one-cycle pulse; `stopwatch_val` updated.

## Operation
- Mode FSM states: OFF, TIMER, CLOCK, STOPWATCH. `select` is the state encoding, driven directly from the state register.
- Reset state is OFF.
- On each accepted press: OFF→TIMER→CLOCK→STOPWATCH→TIMER. The wrap goes back to TIMER and never returns to OFF; only reset reaches OFF.
- Button path:
  - 2-flop synchroniser, then a saturating 8-bit counter.
  - The counter increments while the synchronised level is 1 and clears to 0 when it is 0.
  - A press is accepted on the single edge where the counter reaches `DEBOUNCE_CYCLES`.
  - Holding the button produces exactly one advance. A new press needs a synchronised low sample first. Release is not debounced.
- Handshake:
  - `data_ready` = 1 in every state except OFF; it is combinational from state.
  - A transfer occurs on an edge where `data_valid` && `data_ready` are both 1.
  - In OFF, offered data is ignored and no register changes.
- A transfer writes `data_in` into the register selected by the current state (before any advance on the same edge). The matching `load_*` pulse is asserted for the following cycle.
- Simultaneous transfer and accepted press: the data goes to the pre-advance mode's register, and `select` shows the new mode after that edge.
- Reset values: `select`=00, all `*_val`=0, all `load_*`=0, `data_ready`=0, synchroniser and counter cleared.
- Reset mid-debounce discards the partial count. Reset on the same edge as a transfer wins: registers go to 0 and no load pulse is produced.

## Timing
- Press latency: if `mode_btn` is first sampled high at edge 1 and held, `select` changes after edge `DEBOUNCE_CYCLES`+2 (edges 1–2 synchronise, then `DEBOUNCE_CYCLES` counting edges).
- Glitch rejection: a high pulse that is shorter than `DEBOUNCE_CYCLES` synchronised samples causes no advance.
- Write latency: data transferred at edge n appears on `*_val` after edge n. `load_*` is high for exactly the cycle between edges n and n+1.
- Throughput: one transfer per cycle in any non-OFF state. Back-to-back transfers produce back-to-back load pulses.
- `data_ready` follows the new state in the cycle after an advance, with no bubble.

## Structure
- Package `mode_pkg`:
  - `mode_t` enum (MODE_OFF=2'b00, MODE_TIMER=2'b01, MODE_CLOCK=2'b10, MODE_STOPWATCH=2'b11).
  - Width constant `VAL_W`=4.
  - The output selector imports the same package so both ends agree on the encoding.
- Sub-module `btn_debounce`: synchroniser, counter and press-pulse generator. Parameterised by `DEBOUNCE_CYCLES`; one output `press` (single-cycle pulse).
- Top level: mode FSM, the three holding registers and the load-pulse flops.

## Test plan
- Reset, then idle 10 cycles → `select`=00, all `*_val`=0, `data_ready`=0, no load pulses. Offer `data_in`=4'h7 with valid in OFF → nothing changes.
- `DEBOUNCE_CYCLES`=4, hold `mode_btn` high 20 cycles → `select`=01 after edge 6 and stays 01. Release, then press 4 more times → 10, 11, 01, 10 (wrap skips OFF).
- Pulse `mode_btn` high for 3 cycles → no advance. High for 6 cycles → exactly one advance.
- In TIMER, `data_in`=4'h9 with valid for 1 cycle → `timer_val`=9 after that edge, `load_timer` high 1 cycle, `clock_val`/`stopwatch_val` unchanged. Back-to-back values 3, 5 → two consecutive `load_timer` cycles, final value 5.
- Transfer 4'hA on the same edge the press is accepted in CLOCK → `clock_val`=A, `load_clock` pulses, `select`=11.
- Assert `n_rst` low for 1 cycle mid-debounce and during a transfer in STOPWATCH → all outputs at reset values, no load pulse. The partial press does not complete after reset is released.

Source files
------------

// File: rtl/mode_pkg.sv
// Shared mode encoding and datapath width for the mode controller and the display output selector.
package mode_pkg;

   localparam int VAL_W = 4;

   typedef enum logic [1:0] {
      MODE_OFF       = 2'b00,
      MODE_TIMER     = 2'b01,
      MODE_CLOCK     = 2'b10,
      MODE_STOPWATCH = 2'b11
   } mode_t;

   // Each press moves to the next mode; the wrap from STOPWATCH returns to TIMER, never to OFF.
   function automatic mode_t next_mode(input mode_t m);
      case (m)
         MODE_OFF:       return MODE_TIMER;
         MODE_TIMER:     return MODE_CLOCK;
         MODE_CLOCK:     return MODE_STOPWATCH;
         default:        return MODE_TIMER;
      endcase
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button synchroniser plus saturating run-length counter; emits one press pulse per debounced press.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic n_rst,
   input  logic btn,
   output logic press
);

   localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

   logic [1:0] r_sync;
   logic [7:0] r_cnt;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         r_sync <= '0;
         r_cnt  <= '0;
      end else begin
         r_sync <= {r_sync[0], btn};
         if (!r_sync[1])
            r_cnt <= '0;
         else if (r_cnt != 8'hFF)
            r_cnt <= r_cnt + 8'd1;
      end
   end

   // High only on the edge where the count reaches DEBOUNCE_CYCLES, so a held button fires once.
   assign press = r_sync[1] && (r_cnt == CNT_LAST);

endmodule

// File: rtl/mode_select_ctrl.sv
// Mode FSM driving the selector's select code, plus per-mode holding registers fed by a valid/ready entry port.
module mode_select_ctrl
   import mode_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             mode_btn,
   input  logic [VAL_W-1:0] data_in,
   input  logic             data_valid,
   output logic             data_ready,
   output logic [1:0]       select,
   output logic [VAL_W-1:0] timer_val,
   output logic [VAL_W-1:0] clock_val,
   output logic [VAL_W-1:0] stopwatch_val,
   output logic             load_timer,
   output logic             load_clock,
   output logic             load_stopwatch
);

   mode_t            r_state;
   mode_t            w_next_state;
   logic             w_press;
   logic             w_data_ready;
   logic             w_wr_timer;
   logic             w_wr_clock;
   logic             w_wr_stopwatch;
   logic [VAL_W-1:0] r_timer_val;
   logic [VAL_W-1:0] r_clock_val;
   logic [VAL_W-1:0] r_stopwatch_val;
   logic             r_load_timer;
   logic             r_load_clock;
   logic             r_load_stopwatch;

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_btn_debounce (
      .clk  (clk),
      .n_rst(n_rst),
      .btn  (mode_btn),
      .press(w_press)
   );

   always_ff @(posedge clk) begin
      if (!n_rst)
         r_state <= MODE_OFF;
      else
         r_state <= w_next_state;
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      w_next_state   = r_state;
      w_data_ready   = 1'b0;
      w_wr_timer     = 1'b0;
      w_wr_clock     = 1'b0;
      w_wr_stopwatch = 1'b0;
      if (w_press)
         w_next_state = next_mode(r_state);
      case (r_state)
         MODE_TIMER: begin
            w_data_ready = 1'b1;
            w_wr_timer   = data_valid;
         end
         MODE_CLOCK: begin
            w_data_ready = 1'b1;
            w_wr_clock   = data_valid;
         end
         MODE_STOPWATCH: begin
            w_data_ready   = 1'b1;
            w_wr_stopwatch = data_valid;
         end
         default: ;
      endcase
   end

   // Writes target the pre-advance mode; a coincident reset discards the transfer entirely.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         r_timer_val      <= '0;
         r_clock_val      <= '0;
         r_stopwatch_val  <= '0;
         r_load_timer     <= 1'b0;
         r_load_clock     <= 1'b0;
         r_load_stopwatch <= 1'b0;
      end else begin
         r_load_timer     <= w_wr_timer;
         r_load_clock     <= w_wr_clock;
         r_load_stopwatch <= w_wr_stopwatch;
         if (w_wr_timer)     r_timer_val     <= data_in;
         if (w_wr_clock)     r_clock_val     <= data_in;
         if (w_wr_stopwatch) r_stopwatch_val <= data_in;
      end
   end

   assign select         = r_state;
   assign data_ready     = w_data_ready;
   assign timer_val      = r_timer_val;
   assign clock_val      = r_clock_val;
   assign stopwatch_val  = r_stopwatch_val;
   assign load_timer     = r_load_timer;
   assign load_clock     = r_load_clock;
   assign load_stopwatch = r_load_stopwatch;

endmodule
